// File: rtl/bootram_loader.sv
// Boot RAM loader: parses a framed byte stream from the UART receiver and writes the
// payload into the boot RAM, holding the CPU in reset until a frame with a good checksum lands.
module bootram_loader #(
    parameter int          ADDR_W      = 11,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [23:0] TIMEOUT     = 24'd2700000,
    parameter logic [7:0]  RELEASE_CYC = 8'd16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_L, S_LEN_H, S_DATA, S_CHK, S_HOLD, S_FAIL
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    state_t            state, state_next;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       cnt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        sum;
    logic [23:0]       gap;
    logic [7:0]        hold_cnt;

    logic        start, wr, release_cpu, enter_fail;
    logic [15:0] len_in;
    logic        len_ok, watched, timeout_hit;

    assign len_in      = {rx_data, len_lo};
    assign len_ok      = (len_in != 16'd0) && ({1'b0, len_in} <= MAX_LEN);
    assign watched     = (state == S_LEN_L) || (state == S_LEN_H) ||
                         (state == S_DATA)  || (state == S_CHK);
    // gap counts cycles since the last accepted byte; the edge that would make it TIMEOUT fails the frame
    assign timeout_hit = watched && !rx_valid && (gap == TIMEOUT - 24'd1);

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        wr          = 1'b0;
        release_cpu = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next = S_LEN_L;
                    start      = 1'b1;
                end
            end
            S_LEN_L: begin
                if (rx_valid)         state_next = S_LEN_H;
                else if (timeout_hit) state_next = S_FAIL;
            end
            S_LEN_H: begin
                if (rx_valid)         state_next = len_ok ? S_DATA : S_FAIL;
                else if (timeout_hit) state_next = S_FAIL;
            end
            S_DATA: begin
                if (rx_valid) begin
                    wr = 1'b1;
                    if (cnt == len - 16'd1) state_next = S_CHK;
                end else if (timeout_hit) begin
                    state_next = S_FAIL;
                end
            end
            S_CHK: begin
                if (rx_valid)         state_next = (8'(sum + rx_data) == 8'd0) ? S_HOLD : S_FAIL;
                else if (timeout_hit) state_next = S_FAIL;
            end
            S_HOLD: begin
                if (hold_cnt == RELEASE_CYC - 8'd1) begin
                    state_next  = S_IDLE;
                    release_cpu = 1'b1;
                end
            end
            S_FAIL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        enter_fail = (state_next == S_FAIL) && (state != S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len_lo    <= '0;
            len       <= '0;
            cnt       <= '0;
            addr      <= '0;
            sum       <= '0;
            gap       <= '0;
            hold_cnt  <= '0;
            ram_ce    <= 1'b0;
            ram_ad    <= '0;
            ram_din   <= '0;
            cpu_reset <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state  <= state_next;
            ram_ce <= wr;
            if (wr) begin
                ram_ad  <= addr;
                ram_din <= rx_data;
                addr    <= addr + 1'b1;
                sum     <= sum + rx_data;
                cnt     <= cnt + 16'd1;
            end
            if (state == S_LEN_L && rx_valid) len_lo <= rx_data;
            if (state == S_LEN_H && rx_valid) len    <= len_in;
            gap      <= (!watched || rx_valid) ? 24'd0 : gap + 24'd1;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + 8'd1 : 8'd0;
            if (start) begin
                cpu_reset <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
                sum       <= '0;
                addr      <= '0;
                cnt       <= '0;
            end
            if (release_cpu) begin
                cpu_reset <= 1'b0;
                done      <= 1'b1;
            end
            // cpu_reset deliberately left high on failure: the RAM image is not trustworthy
            if (enter_fail) err <= 1'b1;
        end
    end

    assign ram_wre = ram_ce;
    assign busy    = (state != S_IDLE);

endmodule
